node_row_assign: RTL and testbench

NODE_ROW_ASSIGN -- requirements
Module: node_row_assign

---
 rtl/build_pkg.sv | 51 +++++
 rtl/ram_read_delay.sv | 36 +++
 rtl/node_row_assign.sv | 203 ++++++++++++++++++++
 tb/tb_node_row_assign.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/build_pkg.sv
// rtl/build_pkg.sv - Shared nodeHeads/nodeToElement field layout, RAM read latency and row-assign states.
package build_pkg;

    localparam int READ_LAT = 2;

    // nodeHeads word layout
    localparam int NH_BUILT    = 63;
    localparam int NH_PEND     = 62;
    localparam int NH_DEG_HI   = 56;
    localparam int NH_DEG_LO   = 52;
    localparam int NH_LAST_HI  = 51;
    localparam int NH_LAST_LO  = 47;
    localparam int NH_FIRST_HI = 46;
    localparam int NH_FIRST_LO = 42;
    localparam int NH_ROW_HI   = 41;
    localparam int NH_ROW_LO   = 37;

    // nodeToElement word layout
    localparam int NE_END     = 63;
    localparam int NE_NEXT_HI = 62;
    localparam int NE_NEXT_LO = 58;

    typedef enum logic [2:0] {
        IDLE,
        HEAD_RD,
        HEAD_WAIT,
        WALK_RD,
        WALK_WAIT,
        WRITE,
        NEXT,
        DONE
    } state_t;

    // Row and degree land in the head word; the pending bit is cleared once a row is assigned.
    function automatic logic [63:0] head_update(
        input logic [63:0] head,
        input logic [4:0]  row,
        input logic [4:0]  deg,
        input logic        set_deg
    );
        logic [63:0] w;
        w = head;
        w[NH_ROW_HI:NH_ROW_LO] = row;
        if (set_deg) begin
            w[NH_DEG_HI:NH_DEG_LO] = deg;
        end
        w[NH_PEND] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/ram_read_delay.sv
// rtl/ram_read_delay.sv - Counts READ_LAT cycles after a read is issued and pulses ready when data is valid.
module ram_read_delay
    import build_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic start,
    output logic ready
);

    localparam int CW = $clog2(READ_LAT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CW'(READ_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Start is issued in the cycle the address is first driven, so ready lands READ_LAT cycles later.
    assign ready = (cnt_q == CW'(1));

endmodule

// File: rtl/node_row_assign.sv
// rtl/node_row_assign.sv - Assigns matrix rows to built non-ground nodes; NODE_ROW_DEGREE_EN adds element-list degree counting.
module node_row_assign
    import build_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              go,
    output logic              done,
    output logic              err,
    output logic [4:0]        numRows,
    output logic [ADDR_W-1:0] nodeHeads_addr,
    output logic [63:0]       nodeHeads_data,
    output logic              nodeHeads_wren,
    input  logic [63:0]       nodeHeads_out,
    output logic [ADDR_W-1:0] nodeToElement_addr,
    output logic              nodeToElement_wren,
    input  logic [63:0]       nodeToElement_out
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] scan_q, scan_d;
    logic [4:0]        row_q, row_d;
    logic [63:0]       head_q, head_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [4:0]        num_rows_q, num_rows_d;
    logic [ADDR_W-1:0] nh_addr_q, nh_addr_d;
    logic [63:0]       nh_data_q, nh_data_d;
    logic              nh_wren_q, nh_wren_d;
    logic              rd_start;
    logic              rd_ready;

`ifdef NODE_ROW_DEGREE_EN
    localparam logic [ADDR_W:0] HOP_LIMIT = (ADDR_W+1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] DEG_MAX   = (ADDR_W+1)'(31);

    logic [ADDR_W-1:0] ne_addr_q, ne_addr_d;
    logic [ADDR_W:0]   elem_q, elem_d;
    logic [ADDR_W:0]   elem_n;

    function automatic logic [4:0] sat_deg(input logic [ADDR_W:0] n);
        return (n >= DEG_MAX) ? 5'd31 : n[4:0];
    endfunction
`else
    logic unused_ne_out;
    assign unused_ne_out = ^nodeToElement_out;
`endif

    assign rd_start = (state_q == HEAD_RD) || (state_q == WALK_RD);

    ram_read_delay u_rd_delay (
        .clk    (clk),
        .resetn (resetn),
        .start  (rd_start),
        .ready  (rd_ready)
    );

    always_comb begin
        state_d    = state_q;
        scan_d     = scan_q;
        row_d      = row_q;
        head_d     = head_q;
        done_d     = done_q;
        err_d      = err_q;
        num_rows_d = num_rows_q;
        nh_addr_d  = nh_addr_q;
        nh_data_d  = nh_data_q;
        nh_wren_d  = 1'b0;
`ifdef NODE_ROW_DEGREE_EN
        ne_addr_d  = ne_addr_q;
        elem_d     = elem_q;
        elem_n     = elem_q + 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d   = HEAD_RD;
                    scan_d    = '0;
                    nh_addr_d = '0;
                    row_d     = '0;
                    err_d     = 1'b0;
                    done_d    = 1'b0;
                end
            end
            HEAD_RD: state_d = HEAD_WAIT;
            HEAD_WAIT: begin
                if (rd_ready) begin
                    head_d = nodeHeads_out;
                    // Unbuilt nodes and the ground node (address 0) never receive a row.
                    if (!nodeHeads_out[NH_BUILT] || (scan_q == '0)) begin
                        state_d = NEXT;
                    end else begin
`ifdef NODE_ROW_DEGREE_EN
                        elem_d    = '0;
                        ne_addr_d = nodeHeads_out[NH_FIRST_HI:NH_FIRST_LO];
                        state_d   = WALK_RD;
`else
                        nh_data_d = head_update(nodeHeads_out, row_q, 5'd0, 1'b0);
                        nh_wren_d = 1'b1;
                        state_d   = WRITE;
`endif
                    end
                end
            end
`ifdef NODE_ROW_DEGREE_EN
            WALK_RD: state_d = WALK_WAIT;
            WALK_WAIT: begin
                if (rd_ready) begin
                    elem_d = elem_n;
                    if (nodeToElement_out[NE_END]) begin
                        nh_data_d = head_update(head_q, row_q, sat_deg(elem_n), 1'b1);
                        nh_wren_d = 1'b1;
                        state_d   = WRITE;
                    end else if (elem_n == HOP_LIMIT) begin
                        // Visited every entry without an end flag: the list must loop.
                        err_d     = 1'b1;
                        nh_data_d = head_update(head_q, row_q, 5'd31, 1'b1);
                        nh_wren_d = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        ne_addr_d = nodeToElement_out[NE_NEXT_HI:NE_NEXT_LO];
                        state_d   = WALK_RD;
                    end
                end
            end
`else
            WALK_RD, WALK_WAIT: state_d = NEXT;
`endif
            WRITE: begin
                row_d   = (row_q == 5'd31) ? row_q : row_q + 5'd1;
                state_d = NEXT;
            end
            NEXT: begin
                scan_d    = scan_q + 1'b1;
                nh_addr_d = scan_q + 1'b1;
                if (&scan_q) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    num_rows_d = row_q;
                end else begin
                    state_d = HEAD_RD;
                end
            end
            DONE: begin
                if (!go) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            scan_q     <= '0;
            row_q      <= '0;
            head_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            num_rows_q <= '0;
            nh_addr_q  <= '0;
            nh_data_q  <= '0;
            nh_wren_q  <= 1'b0;
`ifdef NODE_ROW_DEGREE_EN
            ne_addr_q  <= '0;
            elem_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            scan_q     <= scan_d;
            row_q      <= row_d;
            head_q     <= head_d;
            done_q     <= done_d;
            err_q      <= err_d;
            num_rows_q <= num_rows_d;
            nh_addr_q  <= nh_addr_d;
            nh_data_q  <= nh_data_d;
            nh_wren_q  <= nh_wren_d;
`ifdef NODE_ROW_DEGREE_EN
            ne_addr_q  <= ne_addr_d;
            elem_q     <= elem_d;
`endif
        end
    end

    assign done               = done_q;
    assign err                = err_q;
    assign numRows            = num_rows_q;
    assign nodeHeads_addr     = nh_addr_q;
    assign nodeHeads_data     = nh_data_q;
    assign nodeHeads_wren     = nh_wren_q;
    assign nodeToElement_wren = 1'b0;
`ifdef NODE_ROW_DEGREE_EN
    assign nodeToElement_addr = ne_addr_q;
`else
    assign nodeToElement_addr = '0;
`endif

endmodule

// File: tb/tb_node_row_assign.sv
// tb/tb_node_row_assign.sv - Randomized self-checking bench for node_row_assign against a list-walk reference model.
`timescale 1ns/1ps
module tb_node_row_assign;
    import build_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        go = 1'b0;
    logic        done, err;
    logic [4:0]  numRows;
    logic [4:0]  nodeHeads_addr;
    logic [63:0] nodeHeads_data;
    logic        nodeHeads_wren;
    logic [63:0] nodeHeads_out;
    logic [4:0]  nodeToElement_addr;
    logic        nodeToElement_wren;
    logic [63:0] nodeToElement_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    node_row_assign #(.ADDR_W(5)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .go                 (go),
        .done               (done),
        .err                (err),
        .numRows            (numRows),
        .nodeHeads_addr     (nodeHeads_addr),
        .nodeHeads_data     (nodeHeads_data),
        .nodeHeads_wren     (nodeHeads_wren),
        .nodeHeads_out      (nodeHeads_out),
        .nodeToElement_addr (nodeToElement_addr),
        .nodeToElement_wren (nodeToElement_wren),
        .nodeToElement_out  (nodeToElement_out)
    );

    // Two-cycle read latency RAMs
    logic [63:0] nh_mem [32];
    logic [63:0] ne_mem [32];
    logic [63:0] exp_mem [32];
    logic [63:0] snap_mem [32];
    logic [63:0] nh_p1, ne_p1;

    always @(posedge clk) begin
        nh_p1             <= nh_mem[nodeHeads_addr];
        nodeHeads_out     <= nh_p1;
        ne_p1             <= ne_mem[nodeToElement_addr];
        nodeToElement_out <= ne_p1;
        if (nodeHeads_wren) nh_mem[nodeHeads_addr] = nodeHeads_data;
    end

    int        wr_count, wr_dup;
    logic      wren_prev = 1'b0;
    logic      nte_moved, nte_wr_seen;
    bit [31:0] addr_seen;

    always @(negedge clk) begin
        if (nodeHeads_wren) begin
            wr_count++;
            if (wren_prev) wr_dup++;
        end
        wren_prev = nodeHeads_wren;
        if (nodeToElement_addr != 5'd0) nte_moved = 1'b1;
        if (nodeToElement_wren) nte_wr_seen = 1'b1;
        addr_seen[nodeHeads_addr] = 1'b1;
    end

    int   exp_rows;
    logic exp_err;

    // Length of the element list starting at first; cyc reports a list with no end in 32 hops.
    function automatic int walk_len(input int first, output logic cyc);
        int p;
        p = first;
        cyc = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            if (ne_mem[p][63]) return (n > 31) ? 31 : n;
            p = int'(ne_mem[p][62:58]);
        end
        cyc = 1'b1;
        return 31;
    endfunction

    task automatic build_expected();
        int          row;
        int          deg;
        logic        cyc;
        logic [63:0] w;
        row = 0;
        exp_err = 1'b0;
        for (int a = 0; a < 32; a++) begin
            exp_mem[a] = nh_mem[a];
            if (a != 0 && nh_mem[a][63]) begin
                w = nh_mem[a];
                w[41:37] = 5'(row);
                w[62] = 1'b0;
`ifdef NODE_ROW_DEGREE_EN
                deg = walk_len(int'(w[46:42]), cyc);
                if (cyc) exp_err = 1'b1;
                w[56:52] = 5'(deg);
`else
                deg = 0;
                cyc = 1'b0;
`endif
                exp_mem[a] = w;
                row++;
            end
        end
        exp_rows = (row > 31) ? 31 : row;
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 32; i++) begin
            nh_mem[i] = {1'b0, 63'({$urandom, $urandom})};
            ne_mem[i] = {$urandom, $urandom};
        end
    endtask

    function automatic logic [63:0] mk_head(input int first);
        logic [63:0] h;
        h = {$urandom, $urandom};
        h[63] = 1'b1;
        h[46:42] = 5'(first);
        return h;
    endfunction

    function automatic logic [63:0] mk_elem(input logic last, input int nxt);
        logic [63:0] e;
        e = {$urandom, $urandom};
        e[63] = last;
        e[62:58] = 5'(nxt);
        return e;
    endfunction

    task automatic run_pass(input string name);
        int bad, first_bad;
        build_expected();
        @(negedge clk);
        wr_count = 0; wr_dup = 0; nte_moved = 1'b0; nte_wr_seen = 1'b0; addr_seen = '0;
        go = 1'b1;
        for (int i = 0; i < 8000 && !done; i++) @(negedge clk);
        vectors++;
        if (!done) begin
            $display("FAIL %s done_timeout: done=%b required 1", name, done);
            miscompares++;
        end
        vectors++;
        if (numRows !== 5'(exp_rows)) begin
            $display("FAIL %s numRows: got %0d expected %0d", name, numRows, exp_rows);
            miscompares++;
        end
        vectors++;
        if (err !== exp_err) begin
            $display("FAIL %s err: got %b expected %b", name, err, exp_err);
            miscompares++;
        end
        vectors++;
        if (wr_count != exp_rows || wr_dup != 0) begin
            $display("FAIL %s writes: got %0d (back-to-back %0d) expected %0d single-cycle",
                     name, wr_count, wr_dup, exp_rows);
            miscompares++;
        end
        bad = 0; first_bad = 0;
        for (int a = 0; a < 32; a++) begin
            if (nh_mem[a] !== exp_mem[a]) begin
                if (bad == 0) first_bad = a;
                bad++;
            end
        end
        vectors++;
        if (bad != 0) begin
            $display("FAIL %s nodeHeads[%0d]: got %h expected %h (%0d bad entries)",
                     name, first_bad, nh_mem[first_bad], exp_mem[first_bad], bad);
            miscompares++;
        end
        vectors++;
        if (nte_wr_seen !== 1'b0) begin
            $display("FAIL %s nodeToElement_wren: got 1 expected 0", name);
            miscompares++;
        end
`ifndef NODE_ROW_DEGREE_EN
        vectors++;
        if (nte_moved !== 1'b0) begin
            $display("FAIL %s nodeToElement_addr: got nonzero expected constant 0", name);
            miscompares++;
        end
`endif
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            $display("FAIL %s done_after_go_low: got %b expected 0", name, done);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        go = 1'b0;
        #3 resetn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({done, err, numRows, nodeHeads_addr, nodeHeads_data, nodeHeads_wren, nodeToElement_addr} !== '0) begin
            $display("FAIL reset_outputs: got done=%b err=%b rows=%0d nha=%0d nhd=%h wren=%b nea=%0d expected all 0",
                     done, err, numRows, nodeHeads_addr, nodeHeads_data, nodeHeads_wren, nodeToElement_addr);
            miscompares++;
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic setup_example();
        clear_mems();
        nh_mem[0] = mk_head(0);
        nh_mem[3] = mk_head(2);
        nh_mem[7] = mk_head(3);
        nh_mem[3][62] = 1'b1;
        ne_mem[0] = mk_elem(1'b0, 1);
        ne_mem[1] = mk_elem(1'b1, 0);
        ne_mem[2] = mk_elem(1'b1, 0);
        ne_mem[3] = mk_elem(1'b0, 4);
        ne_mem[4] = mk_elem(1'b0, 5);
        ne_mem[5] = mk_elem(1'b1, 0);
    endtask

    task automatic test_spec_example();
        logic [63:0] n0;
        setup_example();
        n0 = nh_mem[0];
        run_pass("example");
        vectors++;
        if (nh_mem[3][41:37] !== 5'd0 || nh_mem[7][41:37] !== 5'd1 || nh_mem[0] !== n0 || nh_mem[3][62] !== 1'b0) begin
            $display("FAIL example_rows: got n3=%0d n7=%0d n0=%h expected 0 1 %h", nh_mem[3][41:37], nh_mem[7][41:37], nh_mem[0], n0);
            miscompares++;
        end
`ifdef NODE_ROW_DEGREE_EN
        vectors++;
        if (nh_mem[3][56:52] !== 5'd1 || nh_mem[7][56:52] !== 5'd3) begin
            $display("FAIL example_degree: got n3=%0d n7=%0d expected 1 3", nh_mem[3][56:52], nh_mem[7][56:52]);
            miscompares++;
        end
`endif
    endtask

    task automatic test_no_built();
        clear_mems();
        run_pass("no_built");
        vectors++;
        if (addr_seen !== 32'hFFFF_FFFF) begin
            $display("FAIL no_built_head_reads: got address map %h expected ffffffff", addr_seen);
            miscompares++;
        end
    endtask

    task automatic test_cycle();
        clear_mems();
        nh_mem[5] = mk_head(9);
        nh_mem[11] = mk_head(1);
        ne_mem[9] = mk_elem(1'b0, 9);
        ne_mem[1] = mk_elem(1'b1, 0);
        run_pass("cyclic");
`ifdef NODE_ROW_DEGREE_EN
        vectors++;
        if (nh_mem[5][56:52] !== 5'd31 || nh_mem[11][41:37] !== 5'd1) begin
            $display("FAIL cyclic_degree: got deg5=%0d row11=%0d expected 31 1", nh_mem[5][56:52], nh_mem[11][41:37]);
            miscompares++;
        end
`endif
    endtask

    task automatic test_all_built();
        int bad;
        clear_mems();
        for (int i = 0; i < 32; i++) begin
            nh_mem[i] = mk_head($urandom_range(0, 31));
            ne_mem[i] = mk_elem(($urandom_range(0, 2) == 0), $urandom_range(0, 31));
        end
        ne_mem[31][63] = 1'b1;
        run_pass("all_built");
        bad = 0;
        for (int a = 1; a < 32; a++) if (nh_mem[a][41:37] !== 5'(a - 1)) bad++;
        vectors++;
        if (bad != 0 || numRows !== 5'd31) begin
            $display("FAIL all_built_order: got %0d misplaced rows numRows=%0d expected 0 and 31", bad, numRows);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_walk();
        int waited;
        setup_example();
        for (int i = 0; i < 32; i++) snap_mem[i] = nh_mem[i];
        @(negedge clk);
        go = 1'b1;
        waited = 0;
`ifdef NODE_ROW_DEGREE_EN
        while (dut.state_q != WALK_WAIT && waited < 500) begin @(posedge clk); waited++; end
`else
        while (dut.state_q != HEAD_WAIT && waited < 500) begin @(posedge clk); waited++; end
`endif
        vectors++;
        if (waited >= 500) begin
            $display("FAIL reset_mid_walk_reach: waited %0d cycles, limit 500", waited);
            miscompares++;
        end
        #2 resetn = 1'b0;
        go = 1'b0;
        #1;
        vectors++;
        if (nodeHeads_wren !== 1'b0 || done !== 1'b0 || nodeHeads_addr !== 5'd0 || nodeToElement_addr !== 5'd0) begin
            $display("FAIL reset_mid_walk_async: got wren=%b done=%b nha=%0d nea=%0d expected 0 0 0 0",
                     nodeHeads_wren, done, nodeHeads_addr, nodeToElement_addr);
            miscompares++;
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 32; i++) if (nh_mem[i] !== snap_mem[i]) begin
            vectors++;
            $display("FAIL reset_mid_walk_partial_write: entry %0d got %h expected %h", i, nh_mem[i], snap_mem[i]);
            miscompares++;
            break;
        end
        run_pass("after_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            clear_mems();
            for (int i = 0; i < 32; i++) begin
                if ($urandom_range(0, 1) == 1) nh_mem[i] = mk_head($urandom_range(0, 31));
                ne_mem[i] = mk_elem(($urandom_range(0, 2) == 0), $urandom_range(0, 31));
            end
            run_pass($sformatf("random%0d", it));
        end
    endtask

    task automatic test_back_to_back();
        run_pass("back_to_back");
    endtask

    initial begin
        test_reset();
        test_spec_example();
        test_no_built();
        test_cycle();
        test_all_built();
        test_reset_mid_walk();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
